// File: rtl/rom_scanner_pkg.sv
// Shared types and default geometry for the ROM scanner and its strobe timer.
package rom_scanner_pkg;

    localparam int ROM_ADDR_W   = 3;
    localparam int ROM_DATA_W   = 8;
    localparam int ROM_WAIT_CYC = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_PRESENT,
        ST_DONE
    } state_e;

    // A full scan adds at most 2^aw words of dw bits, so aw extra bits never overflow.
    function automatic int csum_w(input int aw, input int dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/rom_scanner_if.sv
// ROM strobe bus plus the valid/ready word stream, seen from scanner (master) or environment (slave).
interface rom_scanner_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) ();

    logic [ADDR_W-1:0] rom_addr;
    logic              rom_cs;
    logic              rom_rd;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output rom_addr, rom_cs, rom_rd, out_data, out_addr, out_valid,
        input  rom_data, out_ready
    );

    modport slave (
        input  rom_addr, rom_cs, rom_rd, out_data, out_addr, out_valid,
        output rom_data, out_ready
    );

endinterface

// File: rtl/rom_strobe_timer.sv
// Counts the strobe hold window down from WAIT_CYC and flags the edge on which ROM data is sampled.
module rom_strobe_timer
    import rom_scanner_pkg::*;
#(
    parameter int WAIT_CYC = ROM_WAIT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic sample
);

    localparam int CNT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(WAIT_CYC);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sample = en && (cnt_q == '0);

endmodule

// File: rtl/rom_scanner.sv
// Reads a wrapping range of ROM words, presents each on a valid/ready stream and sums them.
module rom_scanner
    import rom_scanner_pkg::*;
#(
    parameter int  ADDR_W   = ROM_ADDR_W,
    parameter int  DATA_W   = ROM_DATA_W,
    parameter int  WAIT_CYC = ROM_WAIT_CYC,
    localparam int CSUM_W   = csum_w(ADDR_W, DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic [CSUM_W-1:0] checksum,
    rom_scanner_if.master     bus
);

    state_e            state_q,     state_d;
    logic [ADDR_W:0]   remain_q,    remain_d;
    logic [ADDR_W-1:0] rom_addr_q,  rom_addr_d;
    logic              strobe_q,    strobe_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
    logic              out_valid_q, out_valid_d;
    logic [CSUM_W-1:0] checksum_q,  checksum_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              timer_load;
    logic              in_access;
    logic              sample;

    assign in_access = (state_q == ST_ACCESS);

    rom_strobe_timer #(
        .WAIT_CYC (WAIT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .en     (in_access),
        .sample (sample)
    );

    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        rom_addr_d  = rom_addr_q;
        strobe_d    = strobe_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        checksum_d  = checksum_q;
        timer_load  = 1'b0;
        done_d      = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    checksum_d = '0;
                    if (count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_ACCESS;
                        rom_addr_d = start_addr;
                        remain_d   = count;
                        strobe_d   = 1'b1;
                        timer_load = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (sample) begin
                    out_data_d  = bus.rom_data;
                    out_addr_d  = rom_addr_q;
                    checksum_d  = checksum_q + {{ADDR_W{1'b0}}, bus.rom_data};
                    strobe_d    = 1'b0;
                    remain_d    = remain_q - 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                // The handshake edge also relaunches the strobes for the next word.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (remain_q != '0) begin
                        rom_addr_d = rom_addr_q + 1'b1;
                        strobe_d   = 1'b1;
                        timer_load = 1'b1;
                        state_d    = ST_ACCESS;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Busy stays up through the done pulse and falls on the edge after it.
        busy_d = (state_d != ST_IDLE) || (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remain_q    <= '0;
            rom_addr_q  <= '0;
            strobe_q    <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            checksum_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            rom_addr_q  <= rom_addr_d;
            strobe_q    <= strobe_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            checksum_q  <= checksum_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.rom_cs    = strobe_q;
    assign bus.rom_rd    = strobe_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_valid = out_valid_q;
    assign checksum      = checksum_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_rom_scanner.sv
// Directed bench for rom_scanner against an 8-word behavioural ROM with WAIT_CYC=1.
module tb_rom_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  start_addr;
    logic [3:0]  count;
    logic        busy;
    logic        done;
    logic [10:0] checksum;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rom [0:7] = '{8'd22, 8'd2, 8'd12, 8'd4, 8'd14, 8'd13, 8'd11, 8'd44};

    rom_scanner_if #(.ADDR_W(3), .DATA_W(8)) bus ();

    // Data is only driven while both strobes are up, so mis-timed sampling is visible.
    assign bus.rom_data = (bus.rom_cs && bus.rom_rd) ? rom[bus.rom_addr] : 8'h00;

    rom_scanner #(
        .ADDR_W   (3),
        .DATA_W   (8),
        .WAIT_CYC (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   32'(busy),          0);
        chk({tag, "_done"},   32'(done),          0);
        chk({tag, "_raddr"},  32'(bus.rom_addr),  0);
        chk({tag, "_cs"},     32'(bus.rom_cs),    0);
        chk({tag, "_rd"},     32'(bus.rom_rd),    0);
        chk({tag, "_odata"},  32'(bus.out_data),  0);
        chk({tag, "_oaddr"},  32'(bus.out_addr),  0);
        chk({tag, "_ovalid"}, 32'(bus.out_valid), 0);
        chk({tag, "_csum"},   32'(checksum),      0);
    endtask

    task automatic start_scan(input int a, input int c);
        start      = 1'b1;
        start_addr = 3'(a);
        count      = 4'(c);
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid_seen"}, 32'(bus.out_valid), 1);
    endtask

    // Reads n words from a0 with out_ready high; optionally pokes start mid-scan.
    task automatic scan_words(input string tag, input int a0, input int n, input bit poke);
        int         gap;
        logic [2:0] a;
        for (int i = 0; i < n; i++) begin
            a = 3'(a0 + i);
            if (i > 0) begin
                if (poke && i == 1) begin
                    start = 1'b1; start_addr = 3'd0; count = 4'd1;
                end
                tick();
                start = 1'b0;
                chk({tag, "_restrobe"}, 32'(bus.rom_cs), 1);
                chk({tag, "_raddr"},    32'(bus.rom_addr), 32'(a));
            end
            wait_valid(tag, gap);
            chk({tag, "_gap"},   32'(gap), 2);
            chk({tag, "_data"},  32'(bus.out_data), 32'(rom[a]));
            chk({tag, "_oaddr"}, 32'(bus.out_addr), 32'(a));
            chk({tag, "_cs_lo"}, 32'(bus.rom_cs), 0);
        end
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        start         = 1'b0;
        start_addr    = '0;
        count         = '0;
        bus.out_ready = 1'b0;

        #3;
        chk_all_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Full scan 0..7
        bus.out_ready = 1'b1;
        start_scan(0, 8);
        chk("full_strobe_e0", 32'({bus.rom_cs, bus.rom_rd}), 3);
        chk("full_busy_e0",   32'(busy), 1);
        scan_words("full", 0, 8, 1'b0);
        tick();
        chk("full_done_early", 32'(done), 0);
        chk("full_busy_pre",   32'(busy), 1);
        tick();
        chk("full_done",       32'(done), 1);
        chk("full_busy_done",  32'(busy), 1);
        tick();
        chk("full_done_fall",  32'(done), 0);
        chk("full_busy_fall",  32'(busy), 0);
        chk("full_csum",       32'(checksum), 122);

        // Wrap 6,7,0,1 with an ignored start pulse mid-scan
        start_scan(6, 4);
        chk("wrap_csum_clr", 32'(checksum), 0);
        scan_words("wrap", 6, 4, 1'b1);
        tick();
        tick();
        chk("wrap_done", 32'(done), 1);
        chk("wrap_csum", 32'(checksum), 79);
        tick();
        tick();
        chk("wrap_idle_cs", 32'(bus.rom_cs), 0);
        chk("wrap_idle_busy", 32'(busy), 0);

        // Backpressure on the first word
        bus.out_ready = 1'b0;
        start_scan(3, 2);
        wait_valid("bp", n);
        chk("bp_data0", 32'(bus.out_data), 4);
        chk("bp_addr0", 32'(bus.out_addr), 3);
        chk("bp_csum0", 32'(checksum), 4);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_valid", 32'(bus.out_valid), 1);
            chk("bp_hold_data",  32'(bus.out_data), 4);
            chk("bp_hold_addr",  32'(bus.out_addr), 3);
            chk("bp_hold_cs",    32'({bus.rom_cs, bus.rom_rd}), 0);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_hs_valid", 32'(bus.out_valid), 0);
        chk("bp_hs_cs",    32'(bus.rom_cs), 1);
        chk("bp_hs_raddr", 32'(bus.rom_addr), 4);
        wait_valid("bp", n);
        chk("bp_gap",   32'(n), 2);
        chk("bp_data1", 32'(bus.out_data), 14);
        chk("bp_addr1", 32'(bus.out_addr), 4);
        tick();
        tick();
        chk("bp_done", 32'(done), 1);
        chk("bp_csum", 32'(checksum), 18);
        tick();

        // Zero count, with a start pulse while busy
        start_scan(2, 0);
        chk("zero_cs_e0",   32'(bus.rom_cs), 0);
        chk("zero_done_e0", 32'(done), 0);
        chk("zero_busy_e0", 32'(busy), 1);
        chk("zero_csum",    32'(checksum), 0);
        start = 1'b1; start_addr = 3'd2; count = 4'd3;
        tick();
        start = 1'b0;
        chk("zero_done_e1", 32'(done), 1);
        chk("zero_cs_e1",   32'(bus.rom_cs), 0);
        tick();
        chk("zero_done_e2", 32'(done), 0);
        chk("zero_busy_e2", 32'(busy), 0);
        chk("zero_cs_e2",   32'(bus.rom_cs), 0);
        tick();
        chk("zero_cs_e3",    32'(bus.rom_cs), 0);
        chk("zero_busy_e3",  32'(busy), 0);
        chk("zero_valid_e3", 32'(bus.out_valid), 0);

        // Reset during ACCESS of the second word
        start_scan(0, 4);
        wait_valid("rst", n);
        chk("rst_data0", 32'(bus.out_data), 22);
        tick();
        chk("rst_access_cs",   32'(bus.rom_cs), 1);
        chk("rst_access_addr", 32'(bus.rom_addr), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_post_done", 32'(done), 0);
            chk("rst_post_busy", 32'(busy), 0);
            chk("rst_post_cs",   32'(bus.rom_cs), 0);
        end
        start_scan(5, 1);
        wait_valid("rst_new", n);
        chk("rst_new_data", 32'(bus.out_data), 13);
        chk("rst_new_addr", 32'(bus.out_addr), 5);
        tick();
        tick();
        chk("rst_new_done", 32'(done), 1);
        chk("rst_new_csum", 32'(checksum), 13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_scanner.md
# rom_scanner

Read-side controller for the 8-word lookup ROM (3-bit address, 8-bit data, `cs`/`rd` strobes). On a start pulse it reads a contiguous, wrapping range of ROM words and presents each word with its address on a valid/ready output stream. It also accumulates a running checksum. It sits between the ROM and any consumer that needs table contents, such as a display driver or a self-test unit. It owns all ROM strobe timing, so consumers never drive the ROM directly.

## Interface
- `ADDR_W`, 3: ROM address width.
- `DATA_W`, 8: ROM data width.
- `WAIT_CYC`, 1: extra cycles the strobes are held before data is sampled (≥0).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a scan; sampled only in IDLE.
- `start_addr` in ADDR_W: first address of the scan.
- `count` in ADDR_W+1: number of words to read (0..2^ADDR_W).
- `busy` out 1: high while not IDLE.
- `done` out 1: one-cycle pulse when a scan completes.
- `rom_addr` out ADDR_W: ROM address.
- `rom_cs` out 1: ROM chip select.
- `rom_rd` out 1: ROM read strobe.
- `rom_data` in DATA_W: ROM read data.
- `out_data` out DATA_W: captured word.
- `out_addr` out ADDR_W: address of the captured word.
- `out_valid` out 1: the output word is valid.
- `out_ready` in 1: the consumer accepts the word.
- `checksum` out DATA_W+ADDR_W: unsigned sum of all words read in the current or last scan.

## Operation
- States: IDLE, ACCESS, PRESENT, DONE.
- **IDLE**
  - `start`=1 latches `start_addr` and `count`, and clears `checksum` to 0.
  - If `count`=0, go to DONE.
  - Otherwise go to ACCESS with `rom_addr`=`start_addr` and the remaining count set to `count`.
- **ACCESS**
  - `rom_cs`=`rom_rd`=1 and `rom_addr` is stable for exactly WAIT_CYC+1 cycles.
  - The edge ending that window does the following:
    - samples `rom_data` into `out_data` and `rom_addr` into `out_addr`;
    - adds the word zero-extended into `checksum`;
    - drops the strobes;
    - decrements the remaining count;
    - goes to PRESENT.
- **PRESENT**
  - `out_valid`=1; `out_data` and `out_addr` are held stable until the edge with `out_ready`=1.
  - On that handshake edge, if the remaining count is nonzero: `rom_addr` increments modulo 2^ADDR_W (7→0), and the block goes to ACCESS.
  - On that handshake edge, if the remaining count is zero: go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored outside IDLE. A scan cannot be aborted except by reset.
- `checksum` holds its value after DONE until the next accepted `start`.
- Strobes are never asserted outside ACCESS.
- `rom_addr` holds its last value when the strobes are low.

## Timing
- All outputs are registered.
- Reset value of every output is 0: `busy`, `done`, `rom_addr`, `rom_cs`, `rom_rd`, `out_data`, `out_addr`, `out_valid`, `checksum`.
- Let E0 be the edge where `start` is accepted:
  - Strobes are high in the cycles after E0 through E(WAIT_CYC+1).
  - `out_valid` rises at E(WAIT_CYC+1).
- Per-word throughput with `out_ready` held high: WAIT_CYC+2 cycles.
  - The handshake edge is also the edge that reasserts the strobes for the next word.
- `done` rises at the edge after the last handshake, and `busy` falls at the following edge.
- With `count`=0: `done` pulses at E1, no strobe is asserted, and `checksum`=0.
- With `count`=2^ADDR_W: every address is read exactly once, wrapping through 0.
- `out_ready` low for N cycles stalls the block by N cycles with no ROM activity.
- Reset asserted mid-scan:
  - all outputs clear asynchronously;
  - strobes drop immediately;
  - after release the block is in IDLE and no `done` is issued.
- `checksum` width DATA_W+ADDR_W cannot overflow for count ≤ 2^ADDR_W.

## Structure
- A shared package holds:
  - the state enum (IDLE, ACCESS, PRESENT, DONE);
  - the default widths ADDR_W, DATA_W and WAIT_CYC;
  - the checksum width expression.
- One natural sub-module is `rom_strobe_timer`: a down-counter loaded with WAIT_CYC that flags the sample edge.
- The FSM, address counter, and output register stay in the top.

## Test plan
Use a behavioural ROM model containing 22, 2, 12, 4, 14, 13, 11, 44 at addresses 0..7, with WAIT_CYC=1.
- Full scan: `start_addr`=0, `count`=8, `out_ready`=1 → words 22, 2, 12, 4, 14, 13, 11, 44 at addresses 0..7, each 3 cycles apart, then one `done` pulse, and `checksum`=122.
- Wrap: `start_addr`=6, `count`=4 → addresses 6, 7, 0, 1 with data 11, 44, 22, 2; `checksum`=79.
- Backpressure: `start_addr`=3, `count`=2, `out_ready` low for 5 cycles on the first word → `out_data`=4 and `out_addr`=3 held stable, strobes low throughout the stall, then 14 delivered; `checksum`=18.
- Zero count: `start`, `count`=0 → `done` at E1, no `rom_cs` activity, `checksum`=0. A `start` pulsed while `busy` has no effect.
- Reset mid-scan: assert `rst_n`=0 during ACCESS of word 2 → all outputs 0 immediately; after release, a new scan with `start_addr`=5, `count`=1 returns 13 with `checksum`=13.
